// File: rtl/fetch_if.sv
// Bundle of the fetch stage's instruction-memory, consumer and redirect signals.
// master = fetch unit, slave = the memory/decode side that faces it.
`timescale 1ns/1ps
interface fetch_if;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic        br_valid;
  logic [31:0] br_base_pc4;
  logic [31:0] br_offset;
  logic        jmp_valid;
  logic [31:0] jmp_base_pc4;
  logic [25:0] jmp_index;
  logic        misaligned;

  modport master (
    output imem_addr, imem_en, out_valid, out_inst, out_pc, out_pc4, misaligned,
    input  imem_inst, out_ready, br_valid, br_base_pc4, br_offset,
           jmp_valid, jmp_base_pc4, jmp_index
  );

  modport slave (
    input  imem_addr, imem_en, out_valid, out_inst, out_pc, out_pc4, misaligned,
    output imem_inst, out_ready, br_valid, br_base_pc4, br_offset,
           jmp_valid, jmp_base_pc4, jmp_index
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads a 1-cycle synchronous imem, buffers
// returns in a 2-entry FIFO and flushes on branch/jump redirects.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  fif
);

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  logic [31:0] r_fpc;
  logic [31:0] r_tag;
  logic        r_inflight;
  logic        r_misaligned;
  logic [1:0]  r_count;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  entry_t      r_fifo [2];

  logic        w_valid;
  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic        w_redirect;
  logic [2:0]  w_occupied;
  logic [2:0]  w_limit;
  logic [31:0] w_br_target;
  logic [31:0] w_jmp_target;
  logic [31:0] w_target;
  entry_t      w_head;
  logic        w_unused;

  assign w_br_target  = fif.br_base_pc4 + {fif.br_offset[29:0], 2'b00};
  assign w_jmp_target = {fif.jmp_base_pc4[31:28], fif.jmp_index, 2'b00};
  assign w_target     = fif.jmp_valid ? w_jmp_target : w_br_target;
  assign w_redirect   = fif.br_valid | fif.jmp_valid;

  // Bits that the target formulas deliberately discard.
  assign w_unused = ^{fif.jmp_base_pc4[27:0], fif.br_offset[31:30]};

  assign w_valid = (r_count != 2'd0);
  assign w_pop   = w_valid & fif.out_ready;

  // Issue only while FIFO slots plus the in-flight return leave room,
  // counting the slot freed by this cycle's pop.
  assign w_occupied = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_limit    = 3'd2 + {2'b00, w_pop};
  assign w_issue    = !rst && (w_occupied < w_limit) && !w_redirect;
  assign w_push     = r_inflight && !w_redirect;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      r_fpc        <= RESET_PC_AL;
      r_tag        <= '0;
      r_inflight   <= 1'b0;
      r_misaligned <= 1'b0;
      r_count      <= 2'd0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
    end else begin
      r_misaligned <= w_redirect & (|w_target[1:0]);
      if (w_redirect) begin
        r_fpc      <= {w_target[31:2], 2'b00};
        r_inflight <= 1'b0;
        r_count    <= 2'd0;
        r_wr_ptr   <= 1'b0;
        r_rd_ptr   <= 1'b0;
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_tag <= r_fpc;
          r_fpc <= r_fpc + 32'd4;
        end
        if (w_push) r_wr_ptr <= ~r_wr_ptr;
        if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // NOTE: the payload array is not reset; it is only observable through the
  // outputs, which are masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= '{inst: fif.imem_inst, pc: r_tag};
  end

  assign w_head = r_fifo[r_rd_ptr];

  assign fif.imem_addr  = r_fpc;
  assign fif.imem_en    = w_issue;
  assign fif.out_valid  = w_valid;
  assign fif.out_inst   = w_valid ? w_head.inst : '0;
  assign fif.out_pc     = w_valid ? w_head.pc : '0;
  assign fif.out_pc4    = w_valid ? (w_head.pc + 32'd4) : '0;
  assign fif.misaligned = r_misaligned;

  // Credit accounting must never push into a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (r_count != 2'd3) && !(w_push && !w_pop && (r_count == 2'd2)));

endmodule
